bitmap_row_streamer: RTL and testbench

//  Reads out the 1536-bit bitmap register (64 rows x 24 cols) one row per beat over a valid/ready stream.

---
 rtl/bitmap_pkg.sv | 34 +++
 rtl/bitmap_row_sel.sv | 28 ++
 rtl/bitmap_row_streamer.sv | 140 ++++++++++++++
 tb/tb_bitmap_row_streamer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitmap_pkg.sv
// -----------------------------------------------------------------------------
// bitmap_pkg
// Shared definitions for the 64 x 24 bitmap register and its readers/writers.
// Row r occupies bits [r*BMP_COLS +: BMP_COLS] of the flat bitmap vector.
// Contents:
//   BMP_ROWS, BMP_COLS, BMP_W, ROW_W  geometry constants
//   bmp_t, row_t, row_idx_t           flat bitmap, one row, row index
//   state_e                           row streamer FSM states
//   is_last_row()                     true for row BMP_ROWS-1
// -----------------------------------------------------------------------------
package bitmap_pkg;

    localparam int unsigned BMP_ROWS = 64;
    localparam int unsigned BMP_COLS = 24;
    localparam int unsigned BMP_W    = BMP_ROWS * BMP_COLS;
    localparam int unsigned ROW_W    = $clog2(BMP_ROWS);

    typedef logic [BMP_W-1:0]    bmp_t;
    typedef logic [BMP_COLS-1:0] row_t;
    typedef logic [ROW_W-1:0]    row_idx_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDone   = 2'd2
    } state_e;

    localparam row_idx_t ROW_LAST = row_idx_t'(BMP_ROWS - 1);

    function automatic logic is_last_row(input row_idx_t row);
        return row == ROW_LAST;
    endfunction

endpackage

// File: rtl/bitmap_row_sel.sv
// -----------------------------------------------------------------------------
// bitmap_row_sel
// Combinational BMP_ROWS:1 row multiplexer over the flat bitmap vector.
// Ports:
//   i_bmp       flat bitmap (BMP_W bits)
//   i_row       row index to select
//   o_row_bits  selected row, i_bmp[i_row*BMP_COLS +: BMP_COLS]
// -----------------------------------------------------------------------------
module bitmap_row_sel
    import bitmap_pkg::*;
(
    input  logic [BMP_W-1:0]    i_bmp,
    input  logic [ROW_W-1:0]    i_row,
    output logic [BMP_COLS-1:0] o_row_bits
);

    // Explicit compare-and-select per row keeps every slice constant, so the
    // mux maps cleanly and no wide index arithmetic is needed.
    always_comb begin
        o_row_bits = '0;
        for (int unsigned r = 0; r < BMP_ROWS; r++) begin
            if (i_row == row_idx_t'(r)) begin
                o_row_bits = i_bmp[r*BMP_COLS +: BMP_COLS];
            end
        end
    end

endmodule

// File: rtl/bitmap_row_streamer.sv
// -----------------------------------------------------------------------------
// bitmap_row_streamer
// Snapshots the live bitmap register on start and streams it out one row per
// beat over a valid/ready interface, so the ALU may keep writing the live
// register during scanout.
// Ports:
//   i_clk          clock, all state on rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        capture i_bmr_in and stream one frame (ignored while busy)
//   i_abort        synchronous frame cancel (wins over start and transfer)
//   i_bmr_in       live bitmap register contents
//   o_busy         snapshot held / frame in progress
//   o_out_valid    beat valid
//   i_out_ready    sink accepts beat
//   o_out_data     current row bits
//   o_out_row      current row index
//   o_out_last     current beat is the final row
//   o_frame_done   one-cycle pulse after the final beat is accepted
// All outputs come straight from registers or a decode of the state register;
// there is no combinational path from i_out_ready to any output.
// -----------------------------------------------------------------------------
module bitmap_row_streamer
    import bitmap_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [BMP_W-1:0]    i_bmr_in,
    output logic                o_busy,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [BMP_COLS-1:0] o_out_data,
    output logic [ROW_W-1:0]    o_out_row,
    output logic                o_out_last,
    output logic                o_frame_done
);

    state_e   r_state;
    state_e   w_state_nxt;
    row_idx_t r_row;
    row_idx_t w_row_nxt;
    bmp_t     r_snap;
    logic     w_capture;

    row_t     r_data;
    logic     r_valid;
    logic     r_last;

    bmp_t     w_sel_src;
    row_t     w_sel_bits;
    row_t     w_data_nxt;
    logic     w_valid_nxt;
    logic     w_last_nxt;
    logic     w_xfer;

    assign w_xfer = r_valid & i_out_ready;

    // Next-state / row counter.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_capture   = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Abort in idle suppresses a simultaneous start.
                if (i_start && !i_abort) begin
                    w_capture   = 1'b1;
                    w_row_nxt   = '0;
                    w_state_nxt = StStream;
                end
            end
            StStream: begin
                if (i_abort) begin
                    w_state_nxt = StIdle;
                    w_row_nxt   = '0;
                end else if (w_xfer) begin
                    // Counter stops on the last row instead of wrapping.
                    if (is_last_row(r_row)) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_row_nxt = r_row + row_idx_t'(1);
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
                w_row_nxt   = '0;
            end
            default: begin
                w_state_nxt = StIdle;
                w_row_nxt   = '0;
            end
        endcase
    end

    // On the capture cycle the snapshot register is not loaded yet, so the
    // first row is selected directly from the live input.
    assign w_sel_src = w_capture ? i_bmr_in : r_snap;

    bitmap_row_sel u_row_sel (
        .i_bmp      (w_sel_src),
        .i_row      (w_row_nxt),
        .o_row_bits (w_sel_bits)
    );

    always_comb begin
        w_valid_nxt = (w_state_nxt == StStream);
        w_last_nxt  = w_valid_nxt & is_last_row(w_row_nxt);
        w_data_nxt  = w_valid_nxt ? w_sel_bits : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_row   <= '0;
            r_snap  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            if (w_capture) begin
                r_snap <= i_bmr_in;
            end
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign o_busy       = (r_state != StIdle);
    assign o_frame_done = (r_state == StDone);
    assign o_out_valid  = r_valid;
    assign o_out_data   = r_data;
    assign o_out_row    = r_row;
    assign o_out_last   = r_last;

endmodule

// File: tb/tb_bitmap_row_streamer.sv
module tb_bitmap_row_streamer;
    import bitmap_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                abort;
    logic [BMP_W-1:0]    bmr_in;
    logic                busy;
    logic                out_valid;
    logic                out_ready;
    logic [BMP_COLS-1:0] out_data;
    logic [ROW_W-1:0]    out_row;
    logic                out_last;
    logic                frame_done;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard: expected beats pushed when a frame is loaded.
    logic [BMP_COLS-1:0] q_data[$];
    int                  q_row[$];

    always #5 clk = ~clk;

    bitmap_row_streamer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .i_bmr_in     (bmr_in),
        .o_busy       (busy),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_out_row    (out_row),
        .o_out_last   (out_last),
        .o_frame_done (frame_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: row r = r, mode 1: all ones, otherwise random rows.
    task automatic load_frame(input int mode);
        logic [BMP_COLS-1:0] v;
        q_data.delete();
        q_row.delete();
        for (int r = 0; r < BMP_ROWS; r++) begin
            case (mode)
                0:       v = BMP_COLS'(r);
                1:       v = '1;
                default: v = BMP_COLS'($urandom);
            endcase
            bmr_in[r*BMP_COLS +: BMP_COLS] = v;
            q_data.push_back(v);
            q_row.push_back(r);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        bmr_in    = '1;
        #3;
        n_cmp++;
        if ({busy, out_valid, out_data, out_row, out_last, frame_done} !== '0) begin
            n_err++;
            $display("FAIL reset_hold: got %h expected 0",
                     {busy, out_valid, out_data, out_row, out_last, frame_done});
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if ({busy, out_valid, out_data, out_row, out_last, frame_done} !== '0) begin
                n_err++;
                $display("FAIL reset_idle cycle %0d: got %h expected 0", c,
                         {busy, out_valid, out_data, out_row, out_last, frame_done});
            end
        end
    endtask

    task automatic test_full_frame();
        logic [BMP_COLS-1:0] ed;
        int er;
        load_frame(0);
        out_ready = 1'b1;
        pulse_start();
        n_cmp++;
        if (out_valid !== 1'b1 || out_row !== '0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL full_latency: got valid=%b row=%0d busy=%b expected 1 0 1",
                     out_valid, out_row, busy);
        end
        for (int c = 0; c < 100 && q_data.size() > 0; c++) begin
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL full_bubble cycle %0d: got valid=%b expected 1", c, out_valid);
            end else begin
                ed = q_data.pop_front();
                er = q_row.pop_front();
                if (out_data !== ed || out_row !== ROW_W'(er) || out_last !== (er == 63)) begin
                    n_err++;
                    $display("FAIL full_beat: got data=%h row=%0d last=%b expected %h %0d %b",
                             out_data, out_row, out_last, ed, er, er == 63);
                end
            end
            tick();
        end
        n_cmp++;
        if (q_data.size() != 0) begin
            n_err++;
            $display("FAIL full_count: got %0d beats left expected 0", q_data.size());
        end
        n_cmp++;
        if (frame_done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL full_done: got done=%b busy=%b valid=%b expected 1 1 0",
                     frame_done, busy, out_valid);
        end
        tick();
        n_cmp++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL full_idle: got done=%b busy=%b expected 0 0", frame_done, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]          pat;
        logic                held;
        logic [BMP_COLS-1:0] h_data;
        logic [ROW_W-1:0]    h_row;
        logic                h_last;
        logic [BMP_COLS-1:0] ed;
        int                  er;
        int                  c;
        pat  = 4'b1001;
        held = 1'b0;
        load_frame(2);
        out_ready = 1'b1;
        pulse_start();
        c = 0;
        while (c < 400 && q_data.size() > 0) begin
            out_ready = pat[c % 4];
            if (out_valid !== 1'b1) begin
                n_cmp++;
                n_err++;
                $display("FAIL bp_valid_drop cycle %0d: got valid=%b expected 1", c, out_valid);
            end else begin
                if (held) begin
                    n_cmp++;
                    if (out_data !== h_data || out_row !== h_row || out_last !== h_last) begin
                        n_err++;
                        $display("FAIL bp_hold: got %h/%0d/%b expected %h/%0d/%b",
                                 out_data, out_row, out_last, h_data, h_row, h_last);
                    end
                end
                if (out_ready) begin
                    ed = q_data.pop_front();
                    er = q_row.pop_front();
                    n_cmp++;
                    if (out_data !== ed || out_row !== ROW_W'(er) || out_last !== (er == 63)) begin
                        n_err++;
                        $display("FAIL bp_beat: got data=%h row=%0d last=%b expected %h %0d %b",
                                 out_data, out_row, out_last, ed, er, er == 63);
                    end
                    held = 1'b0;
                end else begin
                    held   = 1'b1;
                    h_data = out_data;
                    h_row  = out_row;
                    h_last = out_last;
                end
            end
            tick();
            c++;
        end
        out_ready = 1'b1;
        n_cmp++;
        if (q_data.size() != 0 || frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL bp_end: got left=%0d done=%b expected 0 1", q_data.size(), frame_done);
        end
        tick();
    endtask

    task automatic test_snapshot();
        int                  done_cnt;
        logic [BMP_COLS-1:0] ed;
        int                  er;
        done_cnt = 0;
        load_frame(1);
        out_ready = 1'b1;
        pulse_start();
        bmr_in = '0;
        for (int c = 0; c < 150; c++) begin
            start = (c == 20);
            if (frame_done) done_cnt++;
            if (out_valid) begin
                n_cmp++;
                if (q_data.size() == 0) begin
                    n_err++;
                    $display("FAIL snap_extra: got beat row=%0d expected none", out_row);
                end else begin
                    ed = q_data.pop_front();
                    er = q_row.pop_front();
                    if (out_data !== ed || out_row !== ROW_W'(er)) begin
                        n_err++;
                        $display("FAIL snap_beat: got %h/%0d expected %h/%0d",
                                 out_data, out_row, ed, er);
                    end
                end
            end
            tick();
        end
        start = 1'b0;
        n_cmp++;
        if (done_cnt != 1 || q_data.size() != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL snap_done: got done=%0d left=%0d busy=%b expected 1 0 0",
                     done_cnt, q_data.size(), busy);
        end
    endtask

    task automatic test_abort();
        logic [BMP_COLS-1:0] ed;
        int                  er;
        int                  c;
        load_frame(2);
        out_ready = 1'b1;
        pulse_start();
        c = 0;
        while (c < 20 && out_valid === 1'b1 && out_row !== ROW_W'(10)) begin
            ed = q_data.pop_front();
            er = q_row.pop_front();
            n_cmp++;
            if (out_data !== ed || out_row !== ROW_W'(er)) begin
                n_err++;
                $display("FAIL abort_pre: got %h/%0d expected %h/%0d", out_data, out_row, ed, er);
            end
            tick();
            c++;
        end
        // Row 10 is presented; it is consumed together with the abort.
        ed = q_data.pop_front();
        er = q_row.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== ed || out_row !== ROW_W'(er) || er != 10) begin
            n_err++;
            $display("FAIL abort_row10: got v=%b %h/%0d expected 1 %h/10",
                     out_valid, out_data, out_row, ed);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || out_row !== '0) begin
                n_err++;
                $display("FAIL abort_idle %0d: got v=%b busy=%b done=%b row=%0d expected 0 0 0 0",
                         k, out_valid, busy, frame_done, out_row);
            end
            tick();
        end
        load_frame(2);
        pulse_start();
        for (int k = 0; k < 100 && q_data.size() > 0; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL abort_restart_valid: got %b expected 1", out_valid);
            end else begin
                ed = q_data.pop_front();
                er = q_row.pop_front();
                if (out_data !== ed || out_row !== ROW_W'(er)) begin
                    n_err++;
                    $display("FAIL abort_restart: got %h/%0d expected %h/%0d",
                             out_data, out_row, ed, er);
                end
            end
            tick();
        end
        n_cmp++;
        if (q_data.size() != 0 || frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL abort_restart_end: got left=%0d done=%b expected 0 1",
                     q_data.size(), frame_done);
        end
        tick();
    endtask

    task automatic test_async_reset();
        logic [BMP_COLS-1:0] ed;
        int                  er;
        int                  c;
        load_frame(2);
        out_ready = 1'b1;
        pulse_start();
        c = 0;
        while (c < 40 && out_valid === 1'b1 && out_row !== ROW_W'(30)) begin
            q_data.pop_front();
            q_row.pop_front();
            tick();
            c++;
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_row !== ROW_W'(30)) begin
            n_err++;
            $display("FAIL rst_reach30: got v=%b row=%0d expected 1 30", out_valid, out_row);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, out_valid, out_data, out_row, out_last, frame_done} !== '0) begin
            n_err++;
            $display("FAIL rst_async: got %h expected 0",
                     {busy, out_valid, out_data, out_row, out_last, frame_done});
        end
        #2 rst_n = 1'b1;
        tick();
        load_frame(2);
        pulse_start();
        for (int k = 0; k < 100 && q_data.size() > 0; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL rst_new_valid: got %b expected 1", out_valid);
            end else begin
                ed = q_data.pop_front();
                er = q_row.pop_front();
                if (out_data !== ed || out_row !== ROW_W'(er)) begin
                    n_err++;
                    $display("FAIL rst_new_beat: got %h/%0d expected %h/%0d",
                             out_data, out_row, ed, er);
                end
            end
            tick();
        end
        n_cmp++;
        if (q_data.size() != 0 || frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL rst_new_end: got left=%0d done=%b expected 0 1",
                     q_data.size(), frame_done);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_snapshot();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
